bus_reader: RTL and testbench

Receiving end of the shared 8-bit tri-state data bus driven by the select block (active-low oe, not_in choosing source 1 or 2). Watches the driver's oe and not_in and waits a settle window. Captures the bus value tagged with its source and buffers captures in a small FIFO. Downstream logic drains the FIFO through a valid/ready handshake. The bus, oe and not_in are all driven from logic on the same clk, so no synchronizers are required.

---
 rtl/bus_reader_if.sv | 27 ++
 rtl/bus_reader.sv | 187 ++++++++++++++++++
 tb/tb_bus_reader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bus_reader_if.sv
// Bus-side and consumer-side signals of bus_reader, grouped for port connection.
// slave = the reader itself; master = whatever drives the bus and drains the FIFO.
interface bus_reader_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]         d_bus;
  logic                     oe;
  logic                     not_in;
  logic [WIDTH-1:0]         d_out;
  logic                     src_out;
  logic                     valid;
  logic                     ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     clr_ovf;

  modport slave (
    input  d_bus, oe, not_in, ready, clr_ovf,
    output d_out, src_out, valid, count, overflow
  );

  modport master (
    output d_bus, oe, not_in, ready, clr_ovf,
    input  d_out, src_out, valid, count, overflow
  );
endinterface

// File: rtl/bus_reader.sv
// Reader for the shared tri-state bus: waits for the driver to settle, captures
// {source, data} once per transfer and queues it in a FIFO drained by valid/ready.
module bus_reader #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  bus_reader_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int EW = WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_cur_src;
  logic            w_src_nxt;
  logic            w_push;
  logic            w_settle_done;

  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW-1:0]   w_rptr_nxt;
  logic [AW:0]     r_count;
  logic [AW:0]     w_count_nxt;
  logic [WIDTH-1:0] r_dout;
  logic            r_src;
  logic            r_valid;
  logic            r_ovf;
  logic            w_full;
  logic            w_pop;
  logic            w_store;
  logic            w_drop;
  logic [EW-1:0]   w_entry;
  logic [EW-1:0]   w_head;

  // The cycle in which oe is first seen low (IDLE, or HOLD on a source change)
  // counts as the first settle cycle, so CAPTURE lands SETTLE cycles after oe falls.
  assign w_settle_done = (int'(r_cnt) + 32'sd1) >= (SETTLE - 32'sd1);

  // FSM state, settle counter and current source tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= CW'(0);
      r_cur_src <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cur_src <= w_src_nxt;
    end
  end

  // FSM next-state and capture strobe
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_src_nxt   = r_cur_src;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.oe) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = CW'(0);
          w_src_nxt   = bus.not_in;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (bus.oe) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.not_in != r_cur_src) begin
          w_cnt_nxt   = CW'(0);
          w_src_nxt   = bus.not_in;
        end else if (w_settle_done) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      ST_CAPTURE: begin
        w_push      = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.oe) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.not_in != r_cur_src) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = CW'(0);
          w_src_nxt   = bus.not_in;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CW'(0);
      end
    endcase
  end

  assign w_entry = {r_cur_src, bus.d_bus};
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = r_valid & bus.ready;
  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign w_store = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  // FIFO bookkeeping: read pointer, occupancy and next head entry
  always_comb begin
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    if (w_pop) begin
      w_rptr_nxt = r_rptr + AW'(1);
    end else begin
      w_rptr_nxt = r_rptr;
    end
    case ({w_store, w_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
    if (w_store && (r_wptr == w_rptr_nxt)) begin
      w_head = w_entry;
    end else begin
      w_head = r_mem[w_rptr_nxt];
    end
  end

  // FIFO storage array
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  // FIFO pointers, registered head, status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= AW'(0);
      r_rptr  <= AW'(0);
      r_count <= (AW+1)'(0);
      r_dout  <= WIDTH'(0);
      r_src   <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_store) begin
        r_wptr <= r_wptr + AW'(1);
      end
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != (AW+1)'(0));
      // Head holds its last value once the FIFO runs empty.
      if (w_count_nxt != (AW+1)'(0)) begin
        {r_src, r_dout} <= w_head;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.d_out    = r_dout;
  assign bus.src_out  = r_src;
  assign bus.valid    = r_valid;
  assign bus.count    = r_count;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_bus_reader.sv
// Scenario bench for bus_reader: expected entries are queued when a transfer is
// driven and compared against the FIFO head as it is drained.
module tb_bus_reader;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [8:0] sb[$];
  logic [8:0] exp_e;

  bus_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bif ();

  bus_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // oe low for n_low cycles, then high for 2 cycles; queue expected entry if it fits
  task automatic transfer(input logic src, input logic [7:0] data, input int n_low);
    bif.not_in = src;
    bif.d_bus  = data;
    bif.oe     = 1'b0;
    if (sb.size() < DEPTH) sb.push_back({src, data});
    cyc(n_low);
    bif.oe = 1'b1;
    cyc(2);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bif.oe = 1'b1; bif.not_in = 1'b0; bif.d_bus = 8'h00;
    bif.ready = 1'b0; bif.clr_ovf = 1'b0;
    cyc(3);
    n_tests++; if (bif.d_out !== 8'h00) begin n_fail++; $display("FAIL reset_d_out got %h exp 00", bif.d_out); end
    n_tests++; if (bif.src_out !== 1'b0) begin n_fail++; $display("FAIL reset_src got %b exp 0", bif.src_out); end
    n_tests++; if (bif.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bif.valid); end
    n_tests++; if (bif.count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bif.count); end
    n_tests++; if (bif.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", bif.overflow); end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_basic;
    bif.not_in = 1'b0; bif.d_bus = 8'hA5; bif.oe = 1'b0;
    sb.push_back({1'b0, 8'hA5});
    cyc(2);
    n_tests++; if (bif.valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b exp 0", bif.valid); end
    cyc(1);
    n_tests++; if (bif.valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid got %b exp 1", bif.valid); end
    cyc(2);
    n_tests++; if (bif.count !== 3'd1) begin n_fail++; $display("FAIL basic_single_capture count got %0d exp 1", bif.count); end
    bif.oe = 1'b1;
    cyc(1);
    exp_e = sb.pop_front();
    n_tests++; if ({bif.src_out, bif.d_out} !== exp_e) begin n_fail++; $display("FAIL basic_head got %h exp %h", {bif.src_out, bif.d_out}, exp_e); end
    bif.ready = 1'b1;
    cyc(1);
    bif.ready = 1'b0;
    n_tests++; if (bif.valid !== 1'b0 || bif.count !== 3'd0) begin n_fail++; $display("FAIL basic_drained valid %b count %0d exp 0 0", bif.valid, bif.count); end
  endtask

  task automatic test_abort;
    bif.not_in = 1'b0; bif.d_bus = 8'h3C; bif.oe = 1'b0;
    cyc(1);
    bif.oe = 1'b1;
    cyc(4);
    n_tests++; if (bif.count !== 3'd0 || bif.valid !== 1'b0) begin n_fail++; $display("FAIL abort count %0d valid %b exp 0 0", bif.count, bif.valid); end
  endtask

  task automatic test_hold_switch;
    bif.not_in = 1'b0; bif.d_bus = 8'h11; bif.oe = 1'b0;
    sb.push_back({1'b0, 8'h11});
    cyc(4);
    bif.not_in = 1'b1; bif.d_bus = 8'h22;
    sb.push_back({1'b1, 8'h22});
    cyc(4);
    bif.oe = 1'b1;
    cyc(1);
    n_tests++; if (bif.count !== 3'd2) begin n_fail++; $display("FAIL switch_count got %0d exp 2", bif.count); end
    for (int k = 0; k < 8 && sb.size() > 0; k++) begin
      exp_e = sb.pop_front();
      n_tests++; if (bif.valid !== 1'b1 || {bif.src_out, bif.d_out} !== exp_e) begin n_fail++; $display("FAIL switch_drain valid %b got %h exp %h", bif.valid, {bif.src_out, bif.d_out}, exp_e); end
      bif.ready = 1'b1;
      cyc(1);
    end
    bif.ready = 1'b0;
  endtask

  task automatic test_overflow;
    bit exp_ovf;
    exp_ovf = 1'b0;
    bif.ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (sb.size() >= DEPTH) exp_ovf = 1'b1;
      transfer(1'b0, 8'(i), 4);
    end
    n_tests++; if (bif.count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d exp 4", bif.count); end
    n_tests++; if (bif.overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag got %b exp %b", bif.overflow, exp_ovf); end
    for (int k = 0; k < 8 && sb.size() > 0; k++) begin
      exp_e = sb.pop_front();
      n_tests++; if (bif.valid !== 1'b1 || {bif.src_out, bif.d_out} !== exp_e) begin n_fail++; $display("FAIL ovf_drain valid %b got %h exp %h", bif.valid, {bif.src_out, bif.d_out}, exp_e); end
      bif.ready = 1'b1;
      cyc(1);
    end
    bif.ready = 1'b0;
    n_tests++; if (bif.count !== 3'd0 || bif.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky count %0d ovf %b exp 0 1", bif.count, bif.overflow); end
    bif.clr_ovf = 1'b1;
    cyc(1);
    bif.clr_ovf = 1'b0;
    n_tests++; if (bif.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", bif.overflow); end
  endtask

  task automatic test_full_push_pop;
    bif.ready = 1'b0;
    for (int i = 1; i <= 4; i++) transfer(i[0], 8'h40 + 8'(i), 4);
    n_tests++; if (bif.count !== 3'd4) begin n_fail++; $display("FAIL fullpp_fill got %0d exp 4", bif.count); end
    bif.not_in = 1'b0; bif.d_bus = 8'h99; bif.oe = 1'b0;
    cyc(2);
    exp_e = sb.pop_front();
    sb.push_back({1'b0, 8'h99});
    n_tests++; if ({bif.src_out, bif.d_out} !== exp_e) begin n_fail++; $display("FAIL fullpp_head got %h exp %h", {bif.src_out, bif.d_out}, exp_e); end
    bif.ready = 1'b1;
    cyc(1);
    bif.ready = 1'b0;
    n_tests++; if (bif.count !== 3'd4 || bif.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpp_status count %0d ovf %b exp 4 0", bif.count, bif.overflow); end
    cyc(2);
    bif.oe = 1'b1;
    cyc(1);
    for (int k = 0; k < 8 && sb.size() > 0; k++) begin
      exp_e = sb.pop_front();
      n_tests++; if (bif.valid !== 1'b1 || {bif.src_out, bif.d_out} !== exp_e) begin n_fail++; $display("FAIL fullpp_drain valid %b got %h exp %h", bif.valid, {bif.src_out, bif.d_out}, exp_e); end
      bif.ready = 1'b1;
      cyc(1);
    end
    bif.ready = 1'b0;
    n_tests++; if (bif.valid !== 1'b0) begin n_fail++; $display("FAIL fullpp_empty valid got %b exp 0", bif.valid); end
  endtask

  task automatic test_async_reset;
    bif.ready = 1'b0;
    transfer(1'b1, 8'h55, 4);
    transfer(1'b0, 8'h66, 4);
    n_tests++; if (bif.count !== 3'd2) begin n_fail++; $display("FAIL arst_queued got %0d exp 2", bif.count); end
    bif.not_in = 1'b0; bif.d_bus = 8'h77; bif.oe = 1'b0;
    cyc(1);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    n_tests++; if (bif.valid !== 1'b0 || bif.count !== 3'd0) begin n_fail++; $display("FAIL arst_immediate valid %b count %0d exp 0 0", bif.valid, bif.count); end
    #1 rst = 1'b0;
    bif.oe = 1'b1;
    cyc(2);
    bif.not_in = 1'b1; bif.d_bus = 8'h88; bif.oe = 1'b0;
    sb.push_back({1'b1, 8'h88});
    cyc(3);
    exp_e = sb.pop_front();
    n_tests++; if (bif.valid !== 1'b1 || {bif.src_out, bif.d_out} !== exp_e) begin n_fail++; $display("FAIL arst_recover valid %b got %h exp %h", bif.valid, {bif.src_out, bif.d_out}, exp_e); end
    n_tests++; if (bif.count !== 3'd1) begin n_fail++; $display("FAIL arst_recover_count got %0d exp 1", bif.count); end
    bif.oe = 1'b1;
    bif.ready = 1'b1;
    cyc(1);
    bif.ready = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_abort();
    test_hold_switch();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
